// File: rtl/regfile_write_arbiter.sv
// Writeback port arbiter: two requester FIFOs drained round-robin into a
// single registered register-file write port, with a per-register busy mask
// for read-after-write hazard stalls.

// One requester FIFO. It keeps a per-entry valid bit so the set of pending
// destination registers can be published without walking the pointers.
module regfile_write_arbiter_fifo #(
  parameter int AW    = 4,
  parameter int DW    = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [AW-1:0]    push_addr,
  input  logic [DW-1:0]    push_data,
  output logic             ready,
  input  logic             pop,
  output logic             head_vld,
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_data,
  output logic [2**AW-1:0] busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] mem_addr;
  logic [DEPTH-1:0][DW-1:0] mem_data;
  logic [DEPTH-1:0]         ent_vld;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic                     push;

  // Ready looks only at the count, so a pop never feeds back into ready.
  assign ready     = (count != CW'(DEPTH));
  assign head_vld  = (count != '0);
  assign push      = push_valid && ready;
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Pointer, count and entry-valid bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage; contents are meaningless unless the entry is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // One-hot destination of every queued entry.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) busy[mem_addr[i]] = 1'b1;
  end
endmodule

module regfile_write_arbiter #(
  parameter int AW    = 4,
  parameter int DW    = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic             regwrite,
  output logic [AW-1:0]    regaddress,
  output logic [DW-1:0]    writedata,
  output logic [2**AW-1:0] busy_mask
);
  localparam int NREQ = 2;
  localparam int NREG = 2**AW;

  logic [NREQ-1:0]           in_valid, in_ready, head_vld, pop;
  logic [NREQ-1:0][AW-1:0]   in_addr, head_addr;
  logic [NREQ-1:0][DW-1:0]   in_data, head_data;
  logic [NREQ-1:0][NREG-1:0] fifo_busy;
  logic                      last_grant;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_addr    = {req1_addr, req0_addr};
  assign in_data    = {req1_data, req0_data};
  assign req0_ready = in_ready[0];
  assign req1_ready = in_ready[1];

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    regfile_write_arbiter_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (in_valid[g]),
      .push_addr  (in_addr[g]),
      .push_data  (in_data[g]),
      .ready      (in_ready[g]),
      .pop        (pop[g]),
      .head_vld   (head_vld[g]),
      .head_addr  (head_addr[g]),
      .head_data  (head_data[g]),
      .busy       (fifo_busy[g])
    );
  end

  // Grant: a lone non-empty FIFO always wins; on a tie, the one not granted
  // at the previous tie wins.
  always_comb begin
    pop = '0;
    if (head_vld[0] && (!head_vld[1] || last_grant)) pop[0] = 1'b1;
    else if (head_vld[1])                            pop[1] = 1'b1;
  end

  // Tie history only moves on ties; reset leaves req0 winning the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_grant <= 1'b1;
    else if (&head_vld)     last_grant <= pop[1];
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite   <= 1'b0;
      regaddress <= '0;
      writedata  <= '0;
    end else begin
      regwrite <= |pop;
      if (pop[0]) begin
        regaddress <= head_addr[0];
        writedata  <= head_data[0];
      end else if (pop[1]) begin
        regaddress <= head_addr[1];
        writedata  <= head_data[1];
      end
    end
  end

  // Pending registers: everything queued plus whatever is on the port.
  always_comb begin
    busy_mask = fifo_busy[0] | fifo_busy[1];
    if (regwrite) busy_mask[regaddress] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and model-checked bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [19:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        regwrite;
  logic [3:0]  regaddress;
  logic [19:0] writedata;
  logic [15:0] busy_mask;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [3:0] a; logic [19:0] d; } ent_t;

  regfile_write_arbiter #(.AW(4), .DW(20), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .regwrite(regwrite), .regaddress(regaddress), .writedata(writedata), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", regwrite); end
    checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL reset_busy got %h want 0000", busy_mask); end
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b%0b want 11", req0_ready, req1_ready); end
    checks++; if (regaddress !== 4'h0 || writedata !== 20'h0) begin errors++; $display("FAIL reset_port got %h/%h want 0/0", regaddress, writedata); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_addr = 4'd3; req0_data = 20'd2;
    tick();
    req0_valid = 0;
    checks++; if (busy_mask !== 16'h0008) begin errors++; $display("FAIL single_busy_q got %h want 0008", busy_mask); end
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL single_lat got %0b want 0", regwrite); end
    tick();
    checks++; if (regwrite !== 1'b1 || regaddress !== 4'd3 || writedata !== 20'd2)
      begin errors++; $display("FAIL single_port got %0b/%h/%h want 1/3/00002", regwrite, regaddress, writedata); end
    checks++; if (busy_mask !== 16'h0008) begin errors++; $display("FAIL single_busy_p got %h want 0008", busy_mask); end
    tick();
    checks++; if (regwrite !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL single_done got %0b/%h want 0/0000", regwrite, busy_mask); end
    checks++; if (regaddress !== 4'd3 || writedata !== 20'd2) begin errors++; $display("FAIL single_hold got %h/%h want 3/00002", regaddress, writedata); end
  endtask

  task automatic test_round_robin();
    req0_valid = 1; req0_addr = 4'd4; req0_data = 20'd4;
    req1_valid = 1; req1_addr = 4'd7; req1_data = 20'd9;
    tick();
    idle_inputs();
    checks++; if (busy_mask !== 16'h0090) begin errors++; $display("FAIL rr_busy got %h want 0090", busy_mask); end
    tick();
    checks++; if (regwrite !== 1'b1 || regaddress !== 4'd4 || writedata !== 20'd4)
      begin errors++; $display("FAIL rr_first got %0b/%h/%h want 1/4/00004", regwrite, regaddress, writedata); end
    tick();
    checks++; if (regwrite !== 1'b1 || regaddress !== 4'd7 || writedata !== 20'd9)
      begin errors++; $display("FAIL rr_second got %0b/%h/%h want 1/7/00009", regwrite, regaddress, writedata); end
    tick();
    checks++; if (regwrite !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL rr_idle got %0b/%h want 0/0000", regwrite, busy_mask); end
    req0_valid = 1; req0_addr = 4'd5; req0_data = 20'd1;
    req1_valid = 1; req1_addr = 4'd6; req1_data = 20'd2;
    tick();
    idle_inputs();
    tick();
    checks++; if (regwrite !== 1'b1 || regaddress !== 4'd6 || writedata !== 20'd2)
      begin errors++; $display("FAIL rr_tie2_first got %0b/%h/%h want 1/6/00002", regwrite, regaddress, writedata); end
    tick();
    checks++; if (regwrite !== 1'b1 || regaddress !== 4'd5 || writedata !== 20'd1)
      begin errors++; $display("FAIL rr_tie2_second got %0b/%h/%h want 1/5/00001", regwrite, regaddress, writedata); end
    tick();
  endtask

  task automatic test_backpressure();
    ent_t w[$];
    int i0 = 0, i1 = 0, n0 = 0, n1 = 0;
    logic f0, f1, seen_full = 0;
    req0_valid = 1; req0_addr = 4'd1; req0_data = 20'd1;
    req1_valid = 1; req1_addr = 4'd8; req1_data = 20'h100;
    for (int c = 0; c < 40; c++) begin
      f0 = req0_valid && req0_ready;
      f1 = req1_valid && req1_ready;
      if (req0_valid && !req0_ready) seen_full = 1;
      tick();
      if (regwrite) w.push_back({regaddress, writedata});
      if (f0) begin
        i0++;
        if (i0 == 4) req0_valid = 0;
        else begin req0_addr = 4'(i0 + 1); req0_data = 20'(i0 + 1); end
      end
      if (f1) begin
        i1++;
        if (i1 == 4) req1_valid = 0;
        else begin req1_addr = 4'(8 + i1); req1_data = 20'(32'h100 + i1); end
      end
    end
    idle_inputs();
    checks++; if (seen_full !== 1'b1) begin errors++; $display("FAIL bp_ready_low got %0b want 1", seen_full); end
    checks++; if (w.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", w.size()); end
    foreach (w[k]) begin
      if (w[k].a < 4'd8) begin
        n0++;
        checks++; if (w[k].a !== 4'(n0) || w[k].d !== 20'(n0))
          begin errors++; $display("FAIL bp_req0_order got %h/%h want %h/%h", w[k].a, w[k].d, 4'(n0), 20'(n0)); end
      end else begin
        checks++; if (w[k].a !== 4'(8 + n1) || w[k].d !== 20'(32'h100 + n1))
          begin errors++; $display("FAIL bp_req1_order got %h/%h want %h/%h", w[k].a, w[k].d, 4'(8 + n1), 20'(32'h100 + n1)); end
        n1++;
      end
    end
  endtask

  task automatic test_waw();
    logic [19:0] rf [16];
    foreach (rf[k]) rf[k] = '0;
    req0_valid = 1; req0_addr = 4'd10; req0_data = 20'hAAAAA;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_addr = 4'd10; req1_data = 20'h55555;
    checks++; if (busy_mask !== 16'h0400) begin errors++; $display("FAIL waw_busy0 got %h want 0400", busy_mask); end
    for (int c = 0; c < 2; c++) begin
      tick();
      req1_valid = 0;
      if (regwrite) rf[regaddress] = writedata;
      checks++; if (busy_mask !== 16'h0400) begin errors++; $display("FAIL waw_busy%0d got %h want 0400", c + 1, busy_mask); end
    end
    tick();
    if (regwrite) rf[regaddress] = writedata;
    checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL waw_clear got %h want 0000", busy_mask); end
    checks++; if (rf[10] !== 20'h55555) begin errors++; $display("FAIL waw_r10 got %h want 55555", rf[10]); end
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req0_addr = 4'd2; req0_data = 20'h11;
    req1_valid = 1; req1_addr = 4'd5; req1_data = 20'h22;
    tick();
    req0_addr = 4'd3; req0_data = 20'h33;
    req1_addr = 4'd6; req1_data = 20'h44;
    tick();
    idle_inputs();
    checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b want 1", regwrite); end
    rst_n = 0;
    #1;
    checks++; if (regwrite !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL mid_async got %0b/%h want 0/0000", regwrite, busy_mask); end
    tick();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_nowrite got %0b want 0", regwrite); end
    end
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b%0b want 11", req0_ready, req1_ready); end
  endtask

  task automatic test_random();
    ent_t q0[$], q1[$], e;
    logic        m_last = 1, m_rw = 0, h0, h1, g0, g1, p0, p1;
    logic [3:0]  m_ad = 0;
    logic [19:0] m_wd = 0;
    logic [15:0] m_busy;
    for (int c = 0; c < 10000; c++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_addr = 4'($urandom); req0_data = 20'($urandom);
      req1_addr = 4'($urandom); req1_data = 20'($urandom);
      checks++; if (req0_ready !== (q0.size() != 2)) begin errors++; $display("FAIL rnd_ready0 cyc %0d got %0b want %0b", c, req0_ready, q0.size() != 2); end
      checks++; if (req1_ready !== (q1.size() != 2)) begin errors++; $display("FAIL rnd_ready1 cyc %0d got %0b want %0b", c, req1_ready, q1.size() != 2); end
      p0 = req0_valid && (q0.size() != 2);
      p1 = req1_valid && (q1.size() != 2);
      h0 = (q0.size() != 0);
      h1 = (q1.size() != 0);
      g0 = h0 && (!h1 || m_last);
      g1 = h1 && !g0;
      m_rw = g0 || g1;
      if (g0) begin e = q0.pop_front(); m_ad = e.a; m_wd = e.d; end
      else if (g1) begin e = q1.pop_front(); m_ad = e.a; m_wd = e.d; end
      if (h0 && h1) m_last = g1;
      if (p0) q0.push_back({req0_addr, req0_data});
      if (p1) q1.push_back({req1_addr, req1_data});
      tick();
      m_busy = '0;
      foreach (q0[k]) m_busy[q0[k].a] = 1'b1;
      foreach (q1[k]) m_busy[q1[k].a] = 1'b1;
      if (m_rw) m_busy[m_ad] = 1'b1;
      checks++; if (regwrite !== m_rw) begin errors++; $display("FAIL rnd_regwrite cyc %0d got %0b want %0b", c, regwrite, m_rw); end
      checks++; if (regaddress !== m_ad || writedata !== m_wd)
        begin errors++; $display("FAIL rnd_port cyc %0d got %h/%h want %h/%h", c, regaddress, writedata, m_ad, m_wd); end
      checks++; if (busy_mask !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %h want %h", c, busy_mask, m_busy); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_waw();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
